mc_control_fsm: RTL

MC_CONTROL_FSM -- requirements
Module: mc_control_fsm

---
 rtl/mc_control_fsm.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/mc_control_fsm.sv
// Multi-cycle CPU main control FSM (Moore): decodes the registered state into datapath enables.
// Optional macro MEM_WAIT_EN: FETCH, MEMRD and MEMWR stall until MemReady is sampled high.
module mc_control_fsm #(
  parameter int STATE_WIDTH = 4
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic [5:0]             Opcode,
  input  logic                   MemReady,
  output logic                   PCWrite,
  output logic                   PCWriteCond,
  output logic                   IorD,
  output logic                   MemRead,
  output logic                   MemWrite,
  output logic                   IRWrite,
  output logic                   MemtoReg,
  output logic                   ALUSrcA,
  output logic                   RegWrite,
  output logic                   RegDst,
  output logic                   Illegal,
  output logic [1:0]             PCSource,
  output logic [1:0]             ALUSrcB,
  output logic [1:0]             ALUOp,
  output logic [STATE_WIDTH-1:0] State
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXEC   = 4'd6,
    ALUWB  = 4'd7,
    BRANCH = 4'd8,
    JUMP   = 4'd9
  } state_t;

  state_t     state, nextState;
  logic [5:0] opcodeQ;
  logic       illegalQ, illegalD;
  logic       memGo;

`ifdef MEM_WAIT_EN
  assign memGo = MemReady;
`else
  logic unusedMemReady;
  assign unusedMemReady = MemReady;
  assign memGo          = 1'b1;
`endif

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state    <= FETCH;
      opcodeQ  <= '0;
      illegalQ <= 1'b0;
    end else begin
      state    <= nextState;
      illegalQ <= illegalD;
      if (state == DECODE) opcodeQ <= Opcode;
    end
  end

  always_comb begin
    nextState = FETCH;
    illegalD  = 1'b0;
    case (state)
      FETCH:  nextState = memGo ? DECODE : FETCH;
      DECODE: begin
        case (Opcode)
          OP_LW, OP_SW: nextState = MEMADR;
          OP_RTYPE:     nextState = EXEC;
          OP_BEQ:       nextState = BRANCH;
          OP_J:         nextState = JUMP;
          default: begin
            nextState = FETCH;
            illegalD  = 1'b1;
          end
        endcase
      end
      // MEMADR steers on the opcode captured during DECODE, not the live input
      MEMADR: begin
        if (opcodeQ == OP_LW)      nextState = MEMRD;
        else if (opcodeQ == OP_SW) nextState = MEMWR;
        else                       nextState = FETCH;
      end
      MEMRD:  nextState = memGo ? MEMWB : MEMRD;
      MEMWR:  nextState = memGo ? FETCH : MEMWR;
      EXEC:   nextState = ALUWB;
      default: nextState = FETCH;
    endcase
  end

  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    MemtoReg    = 1'b0;
    ALUSrcA     = 1'b0;
    RegWrite    = 1'b0;
    RegDst      = 1'b0;
    PCSource    = 2'b00;
    ALUSrcB     = 2'b00;
    ALUOp       = 2'b00;
    case (state)
      FETCH: begin
        MemRead = 1'b1;
        IRWrite = 1'b1;
        ALUSrcB = 2'b01;
        PCWrite = 1'b1;
      end
      DECODE: ALUSrcB = 2'b11;
      MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      MEMRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      MEMWB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
      end
      MEMWR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
      end
      EXEC: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b10;
      end
      ALUWB: begin
        RegWrite = 1'b1;
        RegDst   = 1'b1;
      end
      BRANCH: begin
        ALUSrcA     = 1'b1;
        ALUOp       = 2'b01;
        PCWriteCond = 1'b1;
        PCSource    = 2'b01;
      end
      JUMP: begin
        PCWrite  = 1'b1;
        PCSource = 2'b10;
      end
      default: ;
    endcase
  end

  assign Illegal = illegalQ;
  assign State   = STATE_WIDTH'(state);

endmodule
